arm_ctrl_seq_unit: RTL and testbench
====================================

Name: arm_ctrl_seq_unit

Overview:
- Registered, parametrised decode-stage controller for the ARM968E-S pipeline. It replaces the purely combinational decoder.
- It decodes the same op_code/mode/S/I fields, plus a new block-transfer mode (LDM/STM) that it expands into a sequence of single-register memory micro-ops.
- It supports stall (hold) and flush (bubble) from the hazard unit. Outputs feed the ID/EXE pipeline register path directly.

Parameters:
- NUM_REGS, 16, number of architectural registers; width of reg_list.
- IDX_W, $clog2(NUM_REGS), width of seq_reg_idx.
- WORD_BYTES, 4, byte step between consecutive block-transfer addresses.
- OFF_W, IDX_W+$clog2(WORD_BYTES), width of seq_offset.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decode-stage instruction present.
- op_code  in  4  instruction opcode field.
- mode  in  2  00 ALU, 01 LDR/STR, 10 branch, 11 block transfer.
- s_in  in  1  S bit; for mode 01/11, 1 = load and 0 = store.
- i_in  in  1  I bit; for mode 10, 1 = branch.
- reg_list  in  NUM_REGS  block-transfer register mask (mode 11 only).
- stall  in  1  hold all state and outputs.
- flush  in  1  squash; next outputs are a bubble.
- exe_cmd  out  4  ALU command.
- wb_en  out  1  register writeback enable.
- mem_r_en  out  1  memory read enable.
- mem_w_en  out  1  memory write enable.
- b_out  out  1  branch.
- s_out  out  1  update status flags.
- seq_reg_idx  out  IDX_W  register index of the current block micro-op.
- seq_offset  out  OFF_W  byte offset of the current block micro-op from the base.
- busy  out  1  block sequence still pending; fetch/decode must hold the instruction.

Behaviour:
- Reset (async, rst=1): all outputs 0, pending mask 0, state IDLE.
- Latency: an instruction accepted at edge N has its control outputs valid after edge N (registered, one cycle).
- Accept condition: instr_valid & !stall & !flush & state==IDLE.
- Outputs when no instruction is accepted: all-zero bubble (exe_cmd 0000).
- ALU decode (mode 00), exe_cmd / wb_en:
  - MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101: wb=1.
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000: wb=1.
  - CMP 1010→0100 and TST 1000→0110: wb=0, s_out forced 1.
  - Other ALU ops: s_out=s_in.
  - Undefined opcode: bubble.
- Mode 01:
  - op 0100 with s_in=1 is LDR: exe 0010, wb=1, mem_r=1.
  - op 0100 with s_in=0 is STR: exe 0010, mem_w=1.
  - Any other op: bubble.
- Mode 10:
  - i_in=1: b_out=1, everything else 0.
  - i_in=0: bubble.
- Mode 11 (block transfer), states IDLE and BURST:
  - On accept, take the lowest set bit of reg_list. Emit micro-op: exe 0010, seq_reg_idx=bit index, seq_offset=0.
  - Load micro-op: wb=1, mem_r=1. Store micro-op: mem_w=1.
  - pending is set to reg_list with that bit cleared. Go to BURST if pending≠0.
  - Each unstalled BURST cycle emits the next lowest pending bit, clears it, and adds WORD_BYTES to seq_offset.
  - Return to IDLE when pending becomes 0.
  - busy = |pending (combinational from the register). While busy, new instructions are not accepted.
  - k set bits produce exactly k consecutive micro-ops (absent stall), ascending index, offsets 0, 4, …, 4(k-1).
  - reg_list==0: single bubble, stays IDLE.
- Stall: all registers, outputs and pending hold their values.
- Flush: priority over stall. Next edge outputs become a bubble, pending clears, state goes to IDLE, busy=0. Any remaining burst is abandoned.
- seq_reg_idx and seq_offset are 0 for every non-block output.
- At most one memory enable is high in any cycle. b_out is never high together with any enable.

Decomposition:
- Package arm_ctrl_pkg holds:
  - opcode constants;
  - mode constants (MODE_ALU/MEM/BR/BLK);
  - the EXE_CMD encoding constants;
  - a packed ctrl_t struct (exe_cmd, wb_en, mem_r_en, mem_w_en, b_out, s_out).
- One natural sub-module: lsb_onehot_enc, a priority encoder returning the lowest set index and a valid flag, parametrised by NUM_REGS.

Test Plan:
- Reset with rst=1 mid-burst → all outputs 0 and busy=0 immediately, without waiting for a clock edge.
- ADD (mode 00, op 0100, s_in=1) → next cycle exe_cmd=0010, wb_en=1, s_out=1.
- CMP with s_in=0 → exe_cmd=0100, wb_en=0, s_out=1.
- LDM with reg_list=16'h8005, s_in=1 → micro-ops over 3 cycles:
  - idx 0/2/15, offsets 0/4/8;
  - wb_en=1 and mem_r_en=1 each cycle;
  - busy high for the first 2 output cycles, then 0.
- STM with reg_list=16'h0003 and stall=1 for one cycle after the first micro-op → idx 0 held for two cycles, then idx 1 offset 4 with mem_w_en=1.
- Flush mid-LDM (16'h00F0) after idx 4 → next cycle bubble, busy=0, IDLE.
- Branch (mode 10, i_in=1) → b_out=1 only.
- Empty reg_list → a single bubble, busy never high.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared decode constants, control bundle and sequencer state
// for the ARM968E-S decode-stage controller.
package arm_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_BLK = 2'b11;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b_out;
    logic       s_out;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } seq_state_e;

  function automatic ctrl_t alu_decode(
    input logic [3:0] op,
    input logic       s
  );
    ctrl_t c;
    c = CTRL_NOP;
    c.wb_en = 1'b1;
    c.s_out = s;
    case (op)
      OP_MOV: c.exe_cmd = EXE_MOV;
      OP_MVN: c.exe_cmd = EXE_MVN;
      OP_ADD: c.exe_cmd = EXE_ADD;
      OP_ADC: c.exe_cmd = EXE_ADC;
      OP_SUB: c.exe_cmd = EXE_SUB;
      OP_SBC: c.exe_cmd = EXE_SBC;
      OP_AND: c.exe_cmd = EXE_AND;
      OP_ORR: c.exe_cmd = EXE_ORR;
      OP_EOR: c.exe_cmd = EXE_EOR;
      OP_CMP: begin
        c.exe_cmd = EXE_SUB;
        c.wb_en   = 1'b0;
        c.s_out   = 1'b1;
      end
      OP_TST: begin
        c.exe_cmd = EXE_AND;
        c.wb_en   = 1'b0;
        c.s_out   = 1'b1;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  // One word transfer: address add, then load or store.
  function automatic ctrl_t mem_uop(input logic load);
    ctrl_t c;
    c = CTRL_NOP;
    c.exe_cmd  = EXE_ADD;
    c.wb_en    = load;
    c.mem_r_en = load;
    c.mem_w_en = !load;
    return c;
  endfunction

endpackage

// File: rtl/arm_ctrl_seq_unit_lsb_onehot_enc.sv
// Priority encoder: index of the lowest set bit of a mask,
// with a flag telling whether any bit was set at all.
module lsb_onehot_enc #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] mask,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last write.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arm_ctrl_seq_unit.sv
// Registered decode-stage controller with LDM/STM expansion
// into single-register memory micro-ops.
module arm_ctrl_seq_unit
  import arm_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS),
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = IDX_W + $clog2(WORD_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [3:0]          op_code,
  input  logic [1:0]          mode,
  input  logic                s_in,
  input  logic                i_in,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic                stall,
  input  logic                flush,
  output logic [3:0]          exe_cmd,
  output logic                wb_en,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic                b_out,
  output logic                s_out,
  output logic [IDX_W-1:0]    seq_reg_idx,
  output logic [OFF_W-1:0]    seq_offset,
  output logic                busy
);

  seq_state_e          state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                load_q, load_d;

  logic [NUM_REGS-1:0] enc_in;
  logic [NUM_REGS-1:0] enc_rest;
  logic [NUM_REGS-1:0] enc_bit;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_vld;

  assign enc_in = (state_q == S_BURST) ? pend_q : reg_list;

  lsb_onehot_enc #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_enc (
    .mask  (enc_in),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  always_comb begin
    enc_bit          = '0;
    enc_bit[enc_idx] = enc_vld;
    enc_rest         = enc_in & ~enc_bit;
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    off_d   = off_q;
    pend_d  = pend_q;
    load_d  = load_q;
    if (flush) begin
      state_d = S_IDLE;
      ctrl_d  = CTRL_NOP;
      idx_d   = '0;
      off_d   = '0;
      pend_d  = '0;
    end else if (!stall) begin
      ctrl_d = CTRL_NOP;
      idx_d  = '0;
      off_d  = '0;
      if (state_q == S_BURST) begin
        ctrl_d  = mem_uop(load_q);
        idx_d   = enc_idx;
        off_d   = off_q + OFF_W'(WORD_BYTES);
        pend_d  = enc_rest;
        state_d = (|enc_rest) ? S_BURST : S_IDLE;
      end else if (instr_valid) begin
        unique case (mode)
          MODE_ALU: ctrl_d = alu_decode(op_code, s_in);
          MODE_MEM: begin
            if (op_code == OP_ADD) ctrl_d = mem_uop(s_in);
          end
          MODE_BR: ctrl_d.b_out = i_in;
          MODE_BLK: begin
            if (enc_vld) begin
              ctrl_d  = mem_uop(s_in);
              idx_d   = enc_idx;
              load_d  = s_in;
              pend_d  = enc_rest;
              state_d = (|enc_rest) ? S_BURST : S_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_NOP;
      idx_q   <= '0;
      off_q   <= '0;
      pend_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
    end
  end

  assign exe_cmd     = ctrl_q.exe_cmd;
  assign wb_en       = ctrl_q.wb_en;
  assign mem_r_en    = ctrl_q.mem_r_en;
  assign mem_w_en    = ctrl_q.mem_w_en;
  assign b_out       = ctrl_q.b_out;
  assign s_out       = ctrl_q.s_out;
  assign seq_reg_idx = idx_q;
  assign seq_offset  = off_q;
  assign busy        = |pend_q;

endmodule

// File: tb/tb_arm_ctrl_seq_unit.sv
// Directed self-checking bench for arm_ctrl_seq_unit.
module tb_arm_ctrl_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  op_code;
  logic [1:0]  mode;
  logic        s_in;
  logic        i_in;
  logic [15:0] reg_list;
  logic        stall;
  logic        flush;
  logic [3:0]  exe_cmd;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        b_out;
  logic        s_out;
  logic [3:0]  seq_reg_idx;
  logic [5:0]  seq_offset;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  wire [8:0] ctrl = {exe_cmd, wb_en, mem_r_en, mem_w_en, b_out, s_out};

  always #5 clk = ~clk;

  arm_ctrl_seq_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .op_code     (op_code),
    .mode        (mode),
    .s_in        (s_in),
    .i_in        (i_in),
    .reg_list    (reg_list),
    .stall       (stall),
    .flush       (flush),
    .exe_cmd     (exe_cmd),
    .wb_en       (wb_en),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .b_out       (b_out),
    .s_out       (s_out),
    .seq_reg_idx (seq_reg_idx),
    .seq_offset  (seq_offset),
    .busy        (busy)
  );

  task automatic idle_in();
    instr_valid = 1'b0;
    op_code     = 4'h0;
    mode        = 2'b00;
    s_in        = 1'b0;
    i_in        = 1'b0;
    reg_list    = 16'h0;
    stall       = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic issue(input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic i,
                       input logic [15:0] rl);
    instr_valid = 1'b1;
    mode        = m;
    op_code     = op;
    s_in        = s;
    i_in        = i;
    reg_list    = rl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    #3;
    n_chk++;
    if (ctrl !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp %b", ctrl, 9'h000);
    end
    n_chk++;
    if ({seq_reg_idx, seq_offset} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_seq: got %h exp 0", {seq_reg_idx, seq_offset});
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b exp 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0] ops [6]  = '{4'b0100, 4'b1101, 4'b1010,
                             4'b1000, 4'b0011, 4'b0001};
    logic       ss  [6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] exp [6]  = '{9'b0010_10001, 9'b0001_10000,
                             9'b0100_00001, 9'b0110_00001,
                             9'b0000_00000, 9'b1000_10001};
    for (int k = 0; k < 6; k++) begin
      issue(2'b00, ops[k], ss[k], 1'b0, 16'hFFFF);
      step();
      n_chk++;
      if (ctrl !== exp[k] || seq_reg_idx !== 4'd0 || seq_offset !== 6'd0) begin
        n_fail++;
        $display("FAIL alu_%0d: got %b/%0d/%0d exp %b/0/0",
                 k, ctrl, seq_reg_idx, seq_offset, exp[k]);
      end
    end
    idle_in();
  endtask

  task automatic test_mem_branch();
    logic [1:0] ms  [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [3:0] ops [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    logic       ss  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       is  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] exp [5] = '{9'b0010_11000, 9'b0010_00100,
                            9'b0000_00000, 9'b0000_00010,
                            9'b0000_00000};
    for (int k = 0; k < 5; k++) begin
      issue(ms[k], ops[k], ss[k], is[k], 16'h0000);
      step();
      n_chk++;
      if (ctrl !== exp[k] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL membr_%0d: got %b busy %b exp %b busy 0",
                 k, ctrl, busy, exp[k]);
      end
    end
    idle_in();
  endtask

  task automatic test_ldm();
    logic [3:0] ei [3] = '{4'd0, 4'd2, 4'd15};
    logic [5:0] eo [3] = '{6'd0, 6'd4, 6'd8};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    issue(2'b11, 4'h0, 1'b1, 1'b0, 16'h8005);
    for (int k = 0; k < 3; k++) begin
      step();
      idle_in();
      n_chk++;
      if (ctrl !== 9'b0010_11000 || seq_reg_idx !== ei[k] ||
          seq_offset !== eo[k] || busy !== eb[k]) begin
        n_fail++;
        $display("FAIL ldm_%0d: got %b idx %0d off %0d busy %b exp %b idx %0d off %0d busy %b",
                 k, ctrl, seq_reg_idx, seq_offset, busy,
                 9'b0010_11000, ei[k], eo[k], eb[k]);
      end
    end
    step();
    n_chk++;
    if (ctrl !== 9'h000 || seq_reg_idx !== 4'd0 || seq_offset !== 6'd0) begin
      n_fail++;
      $display("FAIL ldm_end: got %b idx %0d off %0d exp bubble",
               ctrl, seq_reg_idx, seq_offset);
    end
  endtask

  task automatic test_stm_stall();
    logic [3:0] ei [3] = '{4'd0, 4'd0, 4'd1};
    logic [5:0] eo [3] = '{6'd0, 6'd0, 6'd4};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    issue(2'b11, 4'h0, 1'b0, 1'b0, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      step();
      idle_in();
      stall = (k == 0);
      n_chk++;
      if (ctrl !== 9'b0010_00100 || seq_reg_idx !== ei[k] ||
          seq_offset !== eo[k] || busy !== eb[k]) begin
        n_fail++;
        $display("FAIL stm_%0d: got %b idx %0d off %0d busy %b exp %b idx %0d off %0d busy %b",
                 k, ctrl, seq_reg_idx, seq_offset, busy,
                 9'b0010_00100, ei[k], eo[k], eb[k]);
      end
    end
    step();
  endtask

  task automatic test_flush();
    issue(2'b11, 4'h0, 1'b1, 1'b0, 16'h00F0);
    step();
    idle_in();
    n_chk++;
    if (seq_reg_idx !== 4'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got idx %0d busy %b exp idx 4 busy 1",
               seq_reg_idx, busy);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++;
    if (ctrl !== 9'h000 || seq_reg_idx !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %b idx %0d busy %b exp 0 idx 0 busy 0",
               ctrl, seq_reg_idx, busy);
    end
    issue(2'b00, 4'b0100, 1'b0, 1'b0, 16'h0);
    step();
    idle_in();
    n_chk++;
    if (ctrl !== 9'b0010_10000 || seq_offset !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_idle: got %b off %0d exp %b off 0",
               ctrl, seq_offset, 9'b0010_10000);
    end
  endtask

  task automatic test_empty();
    issue(2'b11, 4'h0, 1'b1, 1'b0, 16'h0000);
    step();
    idle_in();
    n_chk++;
    if (ctrl !== 9'h000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_bubble: got %b busy %b exp 0 busy 0", ctrl, busy);
    end
    step();
    n_chk++;
    if (busy !== 1'b0 || ctrl !== 9'h000) begin
      n_fail++;
      $display("FAIL empty_after: got %b busy %b exp 0 busy 0", ctrl, busy);
    end
  endtask

  task automatic test_reset_midburst();
    issue(2'b11, 4'h0, 1'b1, 1'b0, 16'h00F0);
    step();
    idle_in();
    step();
    n_chk++;
    if (busy !== 1'b1 || seq_reg_idx !== 4'd5) begin
      n_fail++;
      $display("FAIL midrst_pre: got busy %b idx %0d exp busy 1 idx 5",
               busy, seq_reg_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ctrl !== 9'h000 || busy !== 1'b0 ||
        seq_reg_idx !== 4'd0 || seq_offset !== 6'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got %b busy %b idx %0d off %0d exp all 0",
               ctrl, busy, seq_reg_idx, seq_offset);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_chk++;
    if (busy !== 1'b0 || ctrl !== 9'h000) begin
      n_fail++;
      $display("FAIL midrst_after: got %b busy %b exp 0 busy 0", ctrl, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mem_branch();
    test_ldm();
    test_stm_stall();
    test_flush();
    test_empty();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
